// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around a combinational 16-bit ALU: decodes, reads the register file
// with forwarding from the in-flight result, and retires td/PSW one cycle later.
module alu_issue_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_N   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_valid,
    input  logic [15:0]              inst,
    output logic                     inst_ready,
    input  logic                     stall,
    input  logic                     cfg_we,
    input  logic [$clog2(REG_N)-1:0] cfg_addr,
    input  logic [DATA_W-1:0]        cfg_data,
    output logic [3:0]               Opcode,
    output logic [DATA_W-1:0]        alu_src1,
    output logic [DATA_W-1:0]        alu_src2,
    output logic [SHAMT_W-1:0]       Opcode_src3,
    output logic                     alu_valid,
    input  logic [DATA_W-1:0]        td,
    input  logic [2:0]               PSW,
    output logic [2:0]               psw_q,
    output logic                     illegal_op,
    output logic [15:0]              retire_cnt,
    input  logic [$clog2(REG_N)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int SEL_W = $clog2(REG_N);

    logic [DATA_W-1:0]  rf [REG_N];
    logic [SEL_W-1:0]   exe_rd;

    logic [3:0]         op_in;
    logic [SEL_W-1:0]   rd_in;
    logic [SEL_W-1:0]   rs1_in;
    logic [SEL_W-1:0]   rs2_in;
    logic [SHAMT_W-1:0] sh_in;
    logic               op_legal;
    logic               op_shift;
    logic               op_unary;
    logic               accept;
    logic               wb;
    logic [DATA_W-1:0]  opnd1;
    logic [DATA_W-1:0]  opnd2;

    assign op_in    = inst[15:12];
    assign rd_in    = inst[11:9];
    assign rs1_in   = inst[8:6];
    assign rs2_in   = inst[5:3];
    assign sh_in    = inst[SHAMT_W-1:0];
    assign op_legal = !op_in[3];
    assign op_shift = (op_in == 4'b0110) || (op_in == 4'b0111);
    assign op_unary = (op_in == 4'b0011);

    assign inst_ready = !stall && !rst;
    assign accept     = inst_valid && inst_ready;
    assign wb         = alu_valid && !stall;

    // The in-flight result retires on the same edge that reads it, so td is bypassed here.
    always_comb begin
        opnd1 = '0;
        if (rs1_in != '0) begin
            if (alu_valid && exe_rd == rs1_in) opnd1 = td;
            else                                opnd1 = rf[rs1_in];
        end
        opnd2 = '0;
        if (rs2_in != '0 && !op_shift && !op_unary) begin
            if (alu_valid && exe_rd == rs2_in) opnd2 = td;
            else                                opnd2 = rf[rs2_in];
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) rf[i] <= '0;
            exe_rd      <= '0;
            Opcode      <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            Opcode_src3 <= '0;
            alu_valid   <= 1'b0;
            psw_q       <= '0;
            illegal_op  <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            // Writeback is placed after the host write so it wins on a shared address.
            if (cfg_we && cfg_addr != '0) rf[cfg_addr] <= cfg_data;
            if (wb && exe_rd != '0)       rf[exe_rd]   <= td;
            if (wb) begin
                psw_q      <= PSW;
                retire_cnt <= retire_cnt + 16'd1;
            end

            illegal_op <= accept && !op_legal;

            if (accept) begin
                Opcode      <= op_in;
                exe_rd      <= rd_in;
                alu_src1    <= opnd1;
                alu_src2    <= opnd2;
                Opcode_src3 <= op_shift ? sh_in : '0;
                alu_valid   <= op_legal;
            end else if (!stall) begin
                alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural ALU closes the loop, a reference model
// tracks architectural state, and issued instructions are scoreboarded through a queue.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;
    logic        stall;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [3:0]  opcode_w;
    logic [15:0] src1_w;
    logic [15:0] src2_w;
    logic [3:0]  src3_w;
    logic        alu_valid;
    logic [15:0] td_w;
    logic [2:0]  psw_w;
    logic [2:0]  psw_q;
    logic        illegal_op;
    logic [15:0] retire_cnt;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .stall(stall), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .Opcode(opcode_w), .alu_src1(src1_w), .alu_src2(src2_w), .Opcode_src3(src3_w),
        .alu_valid(alu_valid), .td(td_w), .PSW(psw_w), .psw_q(psw_q), .illegal_op(illegal_op),
        .retire_cnt(retire_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: returns {zero, overflow, sign, result}.
    function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] sh);
        logic [15:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~a;
            4'd4: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd5: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd6: r = a << sh;
            4'd7: r = a >> sh;
            default: r = '0;
        endcase
        return {(r == 16'd0), ov, r[15], r};
    endfunction

    assign {psw_w, td_w} = alu_f(opcode_w, src1_w, src2_w, src3_w);

    typedef struct {
        logic [3:0]  op;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [3:0]  s3;
        logic        legal;
    } issue_t;

    issue_t issue_q[$];

    logic [15:0] m_rf [8];
    logic        m_valid;
    logic [2:0]  m_rd;
    logic [3:0]  m_op;
    logic [15:0] m_s1, m_s2;
    logic [3:0]  m_s3;
    logic [2:0]  m_psw;
    logic [15:0] m_cnt;
    logic        m_ill;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_valid = 0; m_rd = 0; m_op = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
        m_psw = 0; m_cnt = 0; m_ill = 0;
    endtask

    function automatic logic [15:0] m_opnd(input logic [2:0] rs, input logic [15:0] fwd);
        if (rs == 3'd0) return 16'd0;
        if (m_valid && m_rd == rs) return fwd;
        return m_rf[rs];
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ":alu_valid"}, alu_valid, m_valid);
        check_eq({tag, ":illegal_op"}, illegal_op, m_ill);
        check_eq({tag, ":retire_cnt"}, retire_cnt, m_cnt);
        check_eq({tag, ":psw_q"}, psw_q, m_psw);
        check_eq({tag, ":Opcode"}, opcode_w, m_op);
        check_eq({tag, ":src3"}, src3_w, m_s3);
        if (m_valid) begin
            check_eq({tag, ":src1"}, src1_w, m_s1);
            check_eq({tag, ":src2"}, src2_w, m_s2);
        end
    endtask

    // One clock with the given inputs; model advances alongside and outputs are compared after.
    task automatic cyc(input logic v, input logic [15:0] i, input logic st,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd);
        logic [18:0] fw;
        logic        acc, wbk, legal;
        logic [3:0]  op;
        issue_t      rec, got;
        inst_valid = v; inst = i; stall = st; cfg_we = we; cfg_addr = wa; cfg_data = wd;
        #1;
        check_eq("inst_ready", inst_ready, !st);
        fw    = alu_f(m_op, m_s1, m_s2, m_s3);
        acc   = v && !st;
        wbk   = m_valid && !st;
        op    = i[15:12];
        legal = !op[3];
        rec.op    = op;
        rec.s1    = m_opnd(i[8:6], fw[15:0]);
        rec.s2    = (op == 4'd3 || op == 4'd6 || op == 4'd7) ? 16'd0 : m_opnd(i[5:3], fw[15:0]);
        rec.s3    = (op == 4'd6 || op == 4'd7) ? i[3:0] : 4'd0;
        rec.legal = legal;
        @(posedge clk);
        #1;
        if (we && wa != 3'd0) m_rf[wa] = wd;
        if (wbk && m_rd != 3'd0) m_rf[m_rd] = fw[15:0];
        if (wbk) begin
            m_psw = fw[18:16];
            m_cnt = m_cnt + 16'd1;
        end
        m_ill = acc && !legal;
        if (acc) begin
            issue_q.push_back(rec);
            m_op = rec.op; m_rd = i[11:9]; m_s1 = rec.s1; m_s2 = rec.s2; m_s3 = rec.s3;
            m_valid = legal;
        end else if (!st) begin
            m_valid = 0;
        end
        inst_valid = 0; cfg_we = 0;
        if (acc) begin
            if (issue_q.size() == 0) begin
                check_eq("sb_empty", 16'd1, 16'd0);
            end else begin
                got = issue_q.pop_front();
                check_eq("sb_op", opcode_w, got.op);
                check_eq("sb_src3", src3_w, got.s3);
                check_eq("sb_valid", alu_valid, got.legal);
                if (got.legal) begin
                    check_eq("sb_src1", src1_w, got.s1);
                    check_eq("sb_src2", src2_w, got.s2);
                end
            end
        end
        check_state("cyc");
        dbg_addr = 3'($urandom_range(0, 7));
        #1;
        check_eq("dbg_rand", dbg_data, m_rf[dbg_addr]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 16'h0, 0, 0, 3'd0, 16'h0);
    endtask

    task automatic cfg(input logic [2:0] a, input logic [15:0] d);
        cyc(0, 16'h0, 0, 1, a, d);
    endtask

    task automatic do_reset();
        rst = 1; inst_valid = 1; inst = 16'h4650; stall = 0;
        cfg_we = 1; cfg_addr = 3'd1; cfg_data = 16'hBEEF;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("rst_ready", inst_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        rst = 0; inst_valid = 0; cfg_we = 0;
        model_clear();
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            check_eq("rst_rf", dbg_data, 16'h0000);
        end
        check_state("rst");
    endtask

    task automatic dbg_is(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check_eq(tag, dbg_data, exp);
    endtask

    initial begin
        logic [15:0] ri;
        rst = 1; inst_valid = 0; inst = 0; stall = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        dbg_addr = 0;
        model_clear();
        do_reset();

        // ADD r3 = r1 + r2, then SUB r4 = r3 - r1 back-to-back (r3 forwarded)
        cfg(3'd1, 16'h0003);
        cfg(3'd2, 16'h0005);
        cyc(1, 16'h4650, 0, 0, 3'd0, 16'h0);
        check_eq("add_op", opcode_w, 16'd4);
        check_eq("add_src1", src1_w, 16'h0003);
        check_eq("add_src2", src2_w, 16'h0005);
        cyc(1, 16'h58C8, 0, 0, 3'd0, 16'h0);
        check_eq("fwd_src1", src1_w, 16'h0008);
        check_eq("fwd_src2", src2_w, 16'h0003);
        check_eq("add_retire", retire_cnt, 16'd1);
        dbg_is("add_r3", 3'd3, 16'h0008);
        idle(1);
        dbg_is("sub_r4", 3'd4, 16'h0005);

        // SHL r5 = r2 << 3, then write to r0 which must be dropped
        cyc(1, 16'h6A83, 0, 0, 3'd0, 16'h0);
        check_eq("shl_src2", src2_w, 16'h0000);
        check_eq("shl_src3", src3_w, 16'd3);
        cyc(1, 16'h4050, 0, 0, 3'd0, 16'h0);
        idle(1);
        dbg_is("shl_r5", 3'd5, 16'h0028);
        dbg_is("r0_zero", 3'd0, 16'h0000);
        cfg(3'd0, 16'h1234);
        dbg_is("r0_cfg", 3'd0, 16'h0000);

        // Illegal opcode: one-cycle pulse, nothing retires
        cyc(1, 16'h9000, 0, 0, 3'd0, 16'h0);
        check_eq("ill_pulse", illegal_op, 1'b1);
        check_eq("ill_valid", alu_valid, 1'b0);
        idle(1);
        check_eq("ill_clear", illegal_op, 1'b0);

        // Stall for 3 cycles with an in-flight ADD; cfg still lands during stall
        cyc(1, 16'h4650, 0, 0, 3'd0, 16'h0);
        cyc(0, 16'h0, 1, 1, 3'd6, 16'h00A5);
        cyc(1, 16'h58C8, 1, 0, 3'd0, 16'h0);
        cyc(0, 16'h0, 1, 0, 3'd0, 16'h0);
        check_eq("stall_valid", alu_valid, 1'b1);
        dbg_is("stall_cfg", 3'd6, 16'h00A5);
        idle(1);

        // Writeback and cfg to the same register on one edge: writeback wins
        cyc(1, 16'h4650, 0, 0, 3'd0, 16'h0);
        cfg(3'd3, 16'hAAAA);
        dbg_is("wb_wins", 3'd3, 16'h0008);

        // Randomised traffic with stalls and host writes
        for (int n = 0; n < 300; n++) begin
            ri = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) != 0) ri[15] = 1'b0;
            cyc($urandom_range(0, 3) != 0, ri, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
        end

        // Stall with an in-flight op, then reset: nothing retires, rf cleared
        cyc(1, 16'h4650, 0, 0, 3'd0, 16'h0);
        cyc(0, 16'h0, 1, 0, 3'd0, 16'h0);
        cyc(0, 16'h0, 1, 0, 3'd0, 16'h0);
        stall = 1;
        do_reset();
        stall = 0;
        check_eq("rst_cnt", retire_cnt, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
